ram_sync_init: RTL and testbench
================================

// Module: ram_sync_init
// PURPOSE
//  Parametrised single-port synchronous RAM: registered read, synchronous write, hardware clear-on-reset sweep.
//  Holds loop/sample tables for the looper datapath.
//  Replaces hard-coded byte-select read muxes.
//  Every address 0..DEPTH-1 is readable and writable.
// PARAMETERS
//  DATA_W      8    word width, bits
//  DEPTH       256  number of words, >=2
//  ADDR_W      8    address width; must satisfy 2**ADDR_W >= DEPTH
//  INIT_VALUE  0    word written to every location by the reset sweep
// PORTS
//  clk        in   1       single clock, all logic on rising edge
//  rst        in   1       synchronous, active-high reset
//  req_valid  in   1       request strobe
//  req_ready  out  1       1 = request accepted this cycle (0 while clearing)
//  req_we     in   1       1 = write, 0 = read
//  req_addr   in   ADDR_W  word address
//  req_wdata  in   DATA_W  write data
//  rsp_valid  out  1       read data valid, one-cycle pulse per accepted read
//  rsp_rdata  out  DATA_W  read data; holds last value when rsp_valid=0
//  init_done  out  1       1 once clear sweep has completed
// BEHAVIOUR
//  Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, init_done=0; FSM->CLEAR, clr_cnt=0.
//  FSM CLEAR:
//   - each cycle writes INIT_VALUE to mem[clr_cnt], then clr_cnt++.
//   - when clr_cnt==DEPTH-1 is written, go to RUN.
//   - sweep lasts exactly DEPTH cycles.
//  FSM RUN: init_done=1, req_ready=1 (combinational from state); stays in RUN until rst.
//  Requests: accept = req_valid & req_ready. Unaccepted requests are dropped, not queued.
//  Write: mem[req_addr] <= req_wdata at the accepting edge; no response.
//  Read: the edge after acceptance gives rsp_valid=1 and rsp_rdata=mem[req_addr]. Latency 1 cycle.
//  Back-to-back reads: one per cycle, rsp_valid stays high continuously.
//  Write then read same addr in the next cycle: returns the new data.
//  Out-of-range addr (addr>=DEPTH):
//   - write is ignored, memory unchanged.
//   - read still responds, with rsp_rdata=0.
//  Reset mid-operation:
//   - pending response is squashed (rsp_valid=0 next cycle).
//   - sweep restarts from 0.
//   - any request in the reset cycle is ignored.
//  rst held high: stays in CLEAR at clr_cnt=0, no memory writes.
// CONFIGURATION
//  RAM_OUT_REG_EN defined:
//   - adds a second output register stage; read latency is 2 cycles.
//   - rsp_valid and rsp_rdata are delayed together.
//   - rst clears both stages.
//   - full throughput is retained.
//  RAM_OUT_REG_EN undefined: read latency 1, single output register as above.
// TESTING
//  T1 reset sweep: assert rst 1 cycle, DEPTH=256:
//   - init_done rises exactly 256 cycles after rst falls.
//   - req_ready=0 until then.
//  T2 clear check: after init, read all 256 addrs back-to-back:
//   - 256 consecutive rsp_valid pulses, all data 0x00.
//   - addresses 0 and 1 included.
//  T3 write/read: write 0xA5@0x01, 0x3C@0xFF, then read 0x01, 0xFF:
//   - rsp 0xA5 then 0x3C, one cycle after each read accept.
//  T4 same-addr RAW: write 0x5A@0x10, read 0x10 next cycle:
//   - rsp_rdata=0x5A.
//  T5 out-of-range (DEPTH=200, ADDR_W=8): write 0x77@0xC8, then read 0xC8:
//   - rsp_rdata=0x00.
//   - mem[0..199] unchanged.
//  T6 reset mid-read: read 0x01 (holds 0xA5), assert rst on the response cycle:
//   - rsp_valid=0 after rst, init_done=0.
//   - after re-sweep, read 0x01 returns 0x00.
//   - with RAM_OUT_REG_EN: repeat T3; response arrives 2 cycles after accept.

Source files
------------

// File: rtl/ram_sync_init.sv
// Single-port synchronous RAM with registered read and a clear sweep after reset.
// Optional macro RAM_OUT_REG_EN adds a second output register stage (read latency 2).
module ram_sync_init #(
  parameter int                 DATA_W     = 8,
  parameter int                 DEPTH      = 256,
  parameter int                 ADDR_W     = 8,
  parameter logic [DATA_W-1:0]  INIT_VALUE = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              init_done
);

  // state    | meaning
  // ST_CLEAR | sweeping INIT_VALUE into mem[clr_cnt], requests refused
  // ST_RUN   | sweep finished, requests accepted every cycle
  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   clr_cnt, clr_cnt_nxt;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic                accept;
  logic                in_range;
  logic                rd_valid_q;
  logic [DATA_W-1:0]   rd_data_q;

  assign req_ready = (state == ST_RUN);
  assign init_done = (state == ST_RUN);
  // A request landing in the reset cycle must not touch memory or produce a response.
  assign accept    = req_valid & req_ready & ~rst;
  assign in_range  = ({1'b0, req_addr} < DEPTH_EXT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_CLEAR;
      clr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    mem_we      = 1'b0;
    mem_waddr   = req_addr;
    mem_wdata   = req_wdata;
    case (state)
      ST_CLEAR: begin
        mem_we    = ~rst;
        mem_waddr = clr_cnt;
        mem_wdata = INIT_VALUE;
        if (clr_cnt == LAST_ADDR) begin
          state_nxt   = ST_RUN;
          clr_cnt_nxt = '0;
        end else begin
          clr_cnt_nxt = clr_cnt + 1'b1;
        end
      end
      ST_RUN: begin
        mem_we = accept & req_we & in_range;
      end
      default: state_nxt = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= accept & ~req_we;
      if (accept & ~req_we) rd_data_q <= in_range ? mem[req_addr] : '0;
    end
  end

`ifdef RAM_OUT_REG_EN
  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;

  // Data stage follows the valid stage unconditionally so the pair stays aligned.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= rd_valid_q;
      out_data_q  <= rd_data_q;
    end
  end

  assign rsp_valid = out_valid_q;
  assign rsp_rdata = out_data_q;
`else
  assign rsp_valid = rd_valid_q;
  assign rsp_rdata = rd_data_q;
`endif

endmodule

// File: tb/tb_ram_sync_init.sv
// Scoreboard bench for ram_sync_init: a 256-deep instance for the main tests and
// a 200-deep instance for out-of-range addressing.
module tb_ram_sync_init;

`ifdef RAM_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct {
    logic [7:0] data;
    int         due;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0, req_we = 1'b0;
  logic [7:0] req_addr = '0, req_wdata = '0;
  logic       req_ready, rsp_valid, init_done;
  logic [7:0] rsp_rdata;
  logic       req_valid2 = 1'b0, req_we2 = 1'b0;
  logic [7:0] req_addr2 = '0, req_wdata2 = '0;
  logic       req_ready2, rsp_valid2, init_done2;
  logic [7:0] rsp_rdata2;

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  exp_t q1[$];
  exp_t q2[$];

  ram_sync_init #(.DATA_W(8), .DEPTH(256), .ADDR_W(8), .INIT_VALUE(8'h00)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .init_done(init_done));

  ram_sync_init #(.DATA_W(8), .DEPTH(200), .ADDR_W(8), .INIT_VALUE(8'h00)) dut2 (
    .clk(clk), .rst(rst), .req_valid(req_valid2), .req_ready(req_ready2), .req_we(req_we2),
    .req_addr(req_addr2), .req_wdata(req_wdata2), .rsp_valid(rsp_valid2),
    .rsp_rdata(rsp_rdata2), .init_done(init_done2));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitors: every visible response is matched against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rsp_valid) begin
      if (q1.size() == 0) chk("dut256 unexpected rsp", 32'(rsp_rdata), 32'hFFFF_FFFF);
      else begin
        e = q1.pop_front();
        chk("dut256 rsp data", 32'(rsp_rdata), 32'(e.data));
        chk("dut256 rsp cycle", 32'(cyc), 32'(e.due));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rsp_valid2) begin
      if (q2.size() == 0) chk("dut200 unexpected rsp", 32'(rsp_rdata2), 32'hFFFF_FFFF);
      else begin
        e = q2.pop_front();
        chk("dut200 rsp data", 32'(rsp_rdata2), 32'(e.data));
        chk("dut200 rsp cycle", 32'(cyc), 32'(e.due));
      end
    end
  end

  // Called at posedge+1; drives one request, returns at posedge+1 after the accepting edge.
  task automatic op(input bit d2, input bit we, input logic [7:0] a,
                    input logic [7:0] wd, input logic [7:0] ex);
    if (!d2) begin
      req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd;
    end else begin
      req_valid2 = 1'b1; req_we2 = we; req_addr2 = a; req_wdata2 = wd;
    end
    @(posedge clk); #1;
    if (!we) begin
      if (!d2) q1.push_back('{data: ex, due: cyc + LAT - 1});
      else     q2.push_back('{data: ex, due: cyc + LAT - 1});
    end
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0; req_valid2 = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    bit early;
    int waited;

    // T1: reset state, then sweep length on both instances
    @(posedge clk); #1;
    chk("reset rsp_valid", 32'(rsp_valid), 0);
    chk("reset rsp_rdata", 32'(rsp_rdata), 0);
    chk("reset init_done", 32'(init_done), 0);
    chk("reset req_ready", 32'(req_ready), 0);
    rst = 1'b0;
    early = 1'b0;
    for (int i = 0; i < 256; i++) begin
      if (init_done || req_ready) early = 1'b1;
      if (i == 199) chk("dut200 init before 200", 32'(init_done2), 0);
      if (i == 200) chk("dut200 init at 200", 32'(init_done2), 1);
      @(posedge clk); #1;
    end
    chk("init/ready low during sweep", 32'(early), 0);
    chk("init_done at 256", 32'(init_done), 1);
    chk("req_ready at 256", 32'(req_ready), 1);

    // T2: every location cleared, back-to-back reads
    for (int a = 0; a < 256; a++) op(1'b0, 1'b0, 8'(a), 8'h00, 8'h00);
    idle(3);

    // T3: write/read two addresses, including the top one
    op(1'b0, 1'b1, 8'h01, 8'hA5, 8'h00);
    op(1'b0, 1'b1, 8'hFF, 8'h3C, 8'h00);
    op(1'b0, 1'b0, 8'h01, 8'h00, 8'hA5);
    op(1'b0, 1'b0, 8'hFF, 8'h00, 8'h3C);
    idle(3);
    chk("rdata holds when idle", 32'(rsp_rdata), 32'h3C);
    chk("rsp_valid low when idle", 32'(rsp_valid), 0);

    // T4: write then read the same address on the next cycle
    op(1'b0, 1'b1, 8'h10, 8'h5A, 8'h00);
    op(1'b0, 1'b0, 8'h10, 8'h00, 8'h5A);
    idle(3);

    // T5: out-of-range access on the 200-deep instance
    op(1'b1, 1'b1, 8'hC8, 8'h77, 8'h00);
    op(1'b1, 1'b0, 8'hC8, 8'h00, 8'h00);
    for (int a = 0; a < 200; a++) op(1'b1, 1'b0, 8'(a), 8'h00, 8'h00);
    idle(3);

    // T6: reset asserted in the cycle after the read is accepted
    op(1'b0, 1'b0, 8'h01, 8'h00, 8'hA5);
    if (LAT != 1) void'(q1.pop_back());  // second stage is squashed before it shows
    req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rsp_valid after mid reset", 32'(rsp_valid), 0);
    chk("init_done after mid reset", 32'(init_done), 0);
    waited = 0;
    while (!init_done && waited < 400) begin
      @(posedge clk); #1;
      waited++;
    end
    chk("re-sweep length", 32'(waited), 256);
    op(1'b0, 1'b0, 8'h01, 8'h00, 8'h00);
    idle(4);

    chk("dut256 pending expectations", 32'(q1.size()), 0);
    chk("dut200 pending expectations", 32'(q2.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
